riscv_ifetch: RTL

//  Instruction-fetch stage directly upstream of decode/immediate-extension. Owns the PC, issues word

---
 rtl/riscv_ifetch_pkg.sv | 17 +
 rtl/riscv_ifetch_buf.sv | 47 ++++
 rtl/riscv_ifetch.sv | 92 +++++++++
 3 files changed

// File: rtl/riscv_ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, reset PC,
// FSM state encodings and the canonical NOP word.
package riscv_ifetch_pkg;

  localparam int unsigned BW_DATA_DEF  = 32;
  localparam int unsigned BW_ADDR_DEF  = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFETCH_IDLE  = 2'd0,
    IFETCH_REQ   = 2'd1,
    IFETCH_WAIT  = 2'd2,
    IFETCH_DRAIN = 2'd3
  } ifetch_state_e;

endpackage

// File: rtl/riscv_ifetch_buf.sv
// Two-entry FIFO holding {instr, pc} pairs between instruction memory and decode.
// Flush empties it; stored words keep their old values since they are don't-care when empty.
module riscv_ifetch_buf #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time over req/gnt/rvalid,
// and queues {instr, pc} for decode. A taken redirect flushes everything in flight.
//
// state        | meaning
// IFETCH_IDLE  | first cycle after reset release, no request
// IFETCH_REQ   | request pc_q when the buffer has credit
// IFETCH_WAIT  | one request granted, response will be pushed
// IFETCH_DRAIN | one request granted but redirected, response will be dropped
module riscv_ifetch
  import riscv_ifetch_pkg::*;
#(
  parameter int unsigned        BW_DATA  = BW_DATA_DEF,
  parameter int unsigned        BW_ADDR  = BW_ADDR_DEF,
  parameter logic [BW_ADDR-1:0] RESET_PC = BW_ADDR'(RESET_PC_DEF)
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  output logic               o_imem_req,
  output logic [BW_ADDR-1:0] o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [BW_DATA-1:0] i_imem_rdata,
  input  logic               i_redirect,
  input  logic [BW_ADDR-1:0] i_redirect_pc,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  output logic [BW_DATA-1:0] o_instr,
  output logic [BW_ADDR-1:0] o_instr_pc,
  output logic [BW_ADDR-1:0] o_instr_pc4
);

  ifetch_state_e              state;
  logic [BW_ADDR-1:0]         pc_q;
  logic [BW_ADDR-1:0]         req_pc_q;
  logic [BW_ADDR-1:0]         redirect_pc;
  logic [1:0]                 buf_count;
  logic                       outstanding;
  logic                       credit;
  logic                       fire;
  logic                       push;
  logic                       pop;
  logic [BW_DATA+BW_ADDR-1:0] head;

  // At most one request is ever in flight, so it plus buffered entries must fit in two slots.
  assign outstanding = (state == IFETCH_WAIT) || (state == IFETCH_DRAIN);
  assign credit      = ({1'b0, buf_count} + {2'b00, outstanding}) < 3'd2;
  assign o_imem_req  = (state == IFETCH_REQ) && credit;
  assign o_imem_addr = pc_q;
  assign fire        = o_imem_req && i_imem_gnt;
  assign push        = (state == IFETCH_WAIT) && i_imem_rvalid && !i_redirect;
  assign pop         = o_instr_valid && i_instr_ready;
  assign redirect_pc = i_redirect_pc & ~BW_ADDR'(3);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= IFETCH_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      if (fire) begin
        pc_q     <= pc_q + BW_ADDR'(4);
        req_pc_q <= pc_q;
      end
      if (i_redirect) pc_q <= redirect_pc;
      unique case (state)
        IFETCH_IDLE:  state <= IFETCH_REQ;
        IFETCH_REQ:   if (fire) state <= i_redirect ? IFETCH_DRAIN : IFETCH_WAIT;
        // A response arriving with a redirect is simply not pushed; nothing is left in flight.
        IFETCH_WAIT:  if (i_imem_rvalid) state <= IFETCH_REQ;
                      else if (i_redirect) state <= IFETCH_DRAIN;
        IFETCH_DRAIN: if (i_imem_rvalid) state <= IFETCH_REQ;
        default:      state <= IFETCH_IDLE;
      endcase
    end
  end

  riscv_ifetch_buf #(.W(BW_DATA + BW_ADDR)) u_buf (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .push  (push),
    .pop   (pop),
    .flush (i_redirect),
    .wdata ({i_imem_rdata, req_pc_q}),
    .rdata (head),
    .count (buf_count)
  );

  assign o_instr_valid       = (buf_count != 2'd0);
  assign {o_instr, o_instr_pc} = head;
  assign o_instr_pc4         = o_instr_pc + BW_ADDR'(4);

endmodule
